// File: rtl/wb_master_pipelined_pkg.sv
// wb_pkg: shared state encoding, default widths and command layout for the pipelined Wishbone master
//   Contents: WB_AW/WB_DW/WB_LW default widths, state_t FSM states, cmd_t command record.
package wb_pkg;
    localparam int WB_AW = 16;
    localparam int WB_DW = 16;
    localparam int WB_LW = 8;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    typedef struct packed {
        logic             we;
        logic [WB_AW-1:0] adr;
        logic [WB_LW-1:0] len;
    } cmd_t;
endpackage

// File: rtl/wb_outstanding_cnt.sv
// wb_outstanding_cnt: up/down count of strobed-but-unacknowledged Wishbone beats
//   clk, rst (async, active-low), clr (sync clear), inc (beat issued), dec (ack seen)
//   cnt (current count), full (cnt == MAX_OUT), empty (cnt == 0)
module wb_outstanding_cnt #(
    parameter int MAX_OUT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] cnt,
    output logic       full,
    output logic       empty
);
    assign full  = cnt == 4'(MAX_OUT);
    assign empty = cnt == 4'd0;
    // a simultaneous inc/dec nets to zero; a stray dec at zero is ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !dec)
            cnt <= cnt + 4'd1;
        else if (!inc && dec && !empty)
            cnt <= cnt - 4'd1;
    end
endmodule

// File: rtl/wb_master_pipelined.sv
// wb_master_pipelined: Wishbone B4 pipelined master turning burst commands into pipelined cycles
//   Command:  cmd_valid/cmd_ready, cmd_we, cmd_adr, cmd_len (beats minus one)
//   Write:    wr_valid/wr_ready, wr_dat      Read: rd_valid (pulse), rd_dat
//   Wishbone: cyc_o, stb_o, we_o, adr_o, dat_o, ack_i, stall_i, dat_i; busy mirrors cyc_o
//   rst is asynchronous, active-low.
//   Optional macro WB_MASTER_TIMEOUT_EN adds parameter TIMEOUT and output err_timeout.
module wb_master_pipelined
    import wb_pkg::*;
#(
    parameter int AW      = WB_AW,
    parameter int DW      = WB_DW,
    parameter int LW      = WB_LW,
    parameter int MAX_OUT = 4
`ifdef WB_MASTER_TIMEOUT_EN
    ,parameter int TIMEOUT = 255
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_adr,
    input  logic [LW-1:0] cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_dat,
    output logic          rd_valid,
    output logic [DW-1:0] rd_dat,
    output logic          busy,
    output logic          cyc_o,
    output logic          stb_o,
    output logic          we_o,
    output logic [AW-1:0] adr_o,
    output logic [DW-1:0] dat_o,
    input  logic          ack_i,
    input  logic          stall_i,
    input  logic [DW-1:0] dat_i
`ifdef WB_MASTER_TIMEOUT_EN
    ,output logic         err_timeout
`endif
);
    state_t        state;
    logic          we_r;
    logic [AW-1:0] adr_r;
    logic [LW:0]   beats_left;
    logic [3:0]    out_cnt;
    logic          full, empty, ack, issue, accept, drain_done, abort;

    assign cyc_o     = state != IDLE;
    assign busy      = cyc_o;
    // cmd_ready must read 0 while reset is held, not just after it
    assign cmd_ready = rst && state == IDLE;
    assign accept    = cmd_valid && cmd_ready;
    assign we_o      = cyc_o && we_r;
    assign adr_o     = adr_r;
    assign dat_o     = (state == ISSUE && we_r) ? wr_dat : '0;
    assign stb_o     = state == ISSUE && beats_left != '0 && !full && (!we_r || wr_valid);
    assign issue     = stb_o && !stall_i;
    assign wr_ready  = issue && we_r;
    assign ack       = ack_i && cyc_o;
    // the last outstanding ack may arrive in the same cycle we test for completion
    assign drain_done = empty || (out_cnt == 4'd1 && ack);

    wb_outstanding_cnt #(.MAX_OUT(MAX_OUT)) u_out (
        .clk   (clk),
        .rst   (rst),
        .clr   (abort),
        .inc   (issue),
        .dec   (ack),
        .cnt   (out_cnt),
        .full  (full),
        .empty (empty)
    );

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd;
    assign abort = cyc_o && !ack_i && wd == TW'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd          <= '0;
            err_timeout <= 1'b0;
        end else begin
            wd          <= (!cyc_o || ack_i) ? '0 : wd + TW'(1);
            err_timeout <= abort;
        end
    end
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            we_r       <= 1'b0;
            adr_r      <= '0;
            beats_left <= '0;
            rd_valid   <= 1'b0;
            rd_dat     <= '0;
        end else begin
            rd_valid <= ack && !we_r;
            rd_dat   <= dat_i;
            if (abort)
                state <= IDLE;
            else if (accept)
                state <= ISSUE;
            else if (state == ISSUE && issue && beats_left == (LW+1)'(1))
                state <= DRAIN;
            else if (state == DRAIN && drain_done)
                state <= IDLE;
            if (accept) begin
                we_r       <= cmd_we;
                adr_r      <= cmd_adr;
                beats_left <= (LW+1)'(cmd_len) + (LW+1)'(1);
            end else if (issue) begin
                adr_r      <= adr_r + AW'(1);
                beats_left <= beats_left - (LW+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_wb_master_pipelined.sv
// tb_wb_master_pipelined: randomized scoreboard bench for the pipelined Wishbone master
module tb_wb_master_pipelined;
    localparam int MAXO = 2;

    logic        clk = 0, rst = 1;
    logic        cmd_valid = 0, cmd_ready, cmd_we = 0;
    logic [15:0] cmd_adr = 0;
    logic [7:0]  cmd_len = 0;
    logic        wr_valid = 0, wr_ready;
    logic [15:0] wr_dat = 0;
    logic        rd_valid, busy, cyc_o, stb_o, we_o;
    logic [15:0] rd_dat, adr_o, dat_o;
    logic        ack_i = 0, stall_i = 0;
    logic [15:0] dat_i = 0;
`ifdef WB_MASTER_TIMEOUT_EN
    logic        err_timeout;
`endif

    wb_master_pipelined #(.MAX_OUT(MAXO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_dat(wr_dat),
        .rd_valid(rd_valid), .rd_dat(rd_dat), .busy(busy),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .ack_i(ack_i), .stall_i(stall_i), .dat_i(dat_i)
`ifdef WB_MASTER_TIMEOUT_EN
        ,.err_timeout(err_timeout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {logic [15:0] adr; logic we; logic [15:0] dat;} beat_t;
    typedef struct {logic [15:0] adr; logic we;} pend_t;

    beat_t       exp_q[$];
    logic [15:0] rd_q[$];
    logic [15:0] wq[$];
    pend_t       pend[$];
    logic [15:0] mem[256];
    beat_t       e;
    pend_t       p;
    int n_cmp = 0, n_fail = 0;
    int out_model = 0, cmd_left = 0, n_issued = 0, n_wr = 0, n_rd = 0;
    bit rd_exp_prev = 0, done_prev = 0;
    int stall_pct = 0, ack_pct = 100, wr_pct = 100;

    function automatic logic [7:0] idx(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // slave: random stall, in-order acks at least one cycle after the strobe
    initial forever begin
        @(posedge clk); #1;
        if (!rst) begin
            ack_i = 0;
            stall_i = 0;
        end else begin
            stall_i = $urandom_range(99) < stall_pct;
            ack_i = pend.size() > 0 && $urandom_range(99) < ack_pct;
            dat_i = ack_i ? mem[idx(pend[0].adr)] : 16'($urandom);
        end
    end

    // write data source
    initial forever begin
        @(posedge clk); #1;
        wr_valid = wq.size() > 0 && $urandom_range(99) < wr_pct;
        wr_dat = wq.size() > 0 ? wq[0] : 16'($urandom);
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (rd_valid || rd_exp_prev) chk("rd_valid_latency", rd_valid, rd_exp_prev);
            if (rd_valid) begin
                n_rd++;
                if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_dat", rd_dat, rd_q.pop_front());
            end
            if (done_prev) chk("cyc_drop_after_last_ack", cyc_o, 0);
            rd_exp_prev = 0;
            done_prev = 0;
            if (out_model >= MAXO) chk("stb_while_full", stb_o, 0);
            if (cyc_o && we_o && !wr_valid) chk("stb_without_data", stb_o, 0);
            if (stb_o && stall_i) chk("wr_ready_in_stall", wr_ready, 0);
            if (wr_ready) begin
                n_wr++;
                if (wq.size() > 0) void'(wq.pop_front());
            end
            if (stb_o && !stall_i) begin
                if (exp_q.size() == 0) chk("unexpected_issue", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("issue_adr", adr_o, e.adr);
                    chk("issue_we", we_o, e.we);
                    if (e.we) begin
                        chk("issue_dat", dat_o, e.dat);
                        chk("wr_ready_on_issue", wr_ready, 1);
                    end
                end
                pend.push_back('{adr_o, we_o});
                out_model++;
                n_issued++;
                chk("out_cnt_max", out_model <= MAXO, 1);
            end
            if (ack_i && cyc_o && pend.size() > 0) begin
                p = pend.pop_front();
                out_model--;
                cmd_left--;
                rd_exp_prev = !p.we;
                done_prev = cmd_left == 0;
            end
        end
    end

    task automatic send(input bit we, input logic [15:0] adr, input int len);
        int t;
        logic [15:0] a;
        logic [15:0] d;
        @(posedge clk); #1;
        cmd_valid = 1;
        cmd_we = we;
        cmd_adr = adr;
        cmd_len = 8'(len);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!cmd_ready && t < 5000);
        if (!cmd_ready) chk("cmd_accept_timeout", 0, 1);
        else begin
            chk("idle_gap_cyc_low", cyc_o, 0);
            for (int i = 0; i <= len; i++) begin
                a = adr + 16'(i);
                d = 16'($urandom);
                exp_q.push_back('{a, we, d});
                if (we) wq.push_back(d);
                else rd_q.push_back(mem[idx(a)]);
            end
            cmd_left += len + 1;
        end
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!cmd_ready && t < 5000);
        if (!cmd_ready) chk("idle_timeout", 0, 1);
        @(negedge clk); #1;
    endtask

    task automatic span(input int exp_n, input string nm);
        int c = 0;
        int t = 0;
        while (t < 200) begin
            @(negedge clk);
            t++;
            if (!cyc_o) break;
            c++;
        end
        #1;
        chk(nm, c, exp_n);
    endtask

    initial begin
        int r0, w0, i0, t;
        foreach (mem[i]) mem[i] = 16'($urandom);
        #1 rst = 0;
        #2;
        chk("rst_cyc", cyc_o, 0);
        chk("rst_stb", stb_o, 0);
        chk("rst_we", we_o, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_adr", adr_o, 0);
        chk("rst_dat_o", dat_o, 0);
        chk("rst_rd_dat", rd_dat, 0);
        @(posedge clk); #2 rst = 1;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);

        mem[idx(16'h0010)] = 16'hBEEF;
        r0 = n_rd;
        send(0, 16'h0010, 0);
        span(2, "single_read_cyc_span");
        chk("single_read_rd_count", n_rd - r0, 1);

        w0 = n_wr;
        send(1, 16'h0100, 7);
        span(9, "write8_cyc_span");
        chk("write8_wr_ready_count", n_wr - w0, 8);

        stall_pct = 50;
        r0 = n_rd;
        send(0, 16'hFFFE, 3);
        wait_idle();
        chk("wrap_read_rd_count", n_rd - r0, 4);

        stall_pct = 0;
        ack_pct = 20;
        r0 = n_rd;
        send(0, 16'h0200, 5);
        wait_idle();
        chk("slow_ack_rd_count", n_rd - r0, 6);

        ack_pct = 100;
        wr_pct = 50;
        w0 = n_wr;
        send(1, 16'h0300, 3);
        wait_idle();
        chk("wr_gap_wr_ready_count", n_wr - w0, 4);

        wr_pct = 100;
        ack_pct = 30;
        i0 = n_issued;
        send(1, 16'h0400, 7);
        t = 0;
        while (n_issued - i0 < 3 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("mid_burst_reached_3", n_issued - i0 >= 3, 1);
        @(posedge clk); #2 rst = 0;
        #1;
        chk("mid_rst_cyc", cyc_o, 0);
        chk("mid_rst_stb", stb_o, 0);
        chk("mid_rst_busy", busy, 0);
        exp_q.delete(); rd_q.delete(); wq.delete(); pend.delete();
        out_model = 0; cmd_left = 0; rd_exp_prev = 0; done_prev = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1;
        @(negedge clk);
        chk("after_rst_cmd_ready", cmd_ready, 1);
        chk("after_rst_cyc", cyc_o, 0);

        repeat (40) begin
            stall_pct = $urandom_range(0, 60);
            ack_pct = $urandom_range(20, 100);
            wr_pct = $urandom_range(30, 100);
            send($urandom_range(0, 1) == 1,
                 ($urandom_range(0, 3) == 0) ? 16'hFFFA : 16'($urandom),
                 $urandom_range(0, 11));
        end
        wait_idle();
        chk("end_issue_queue_empty", exp_q.size(), 0);
        chk("end_rd_queue_empty", rd_q.size(), 0);
        chk("end_outstanding_zero", out_model, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1);
    end
endmodule

// File: doc/wb_master_pipelined.md
Name: wb_master_pipelined

Overview:
- Wishbone B4 pipelined master that turns single-beat and burst commands into pipelined read/write cycles.
- Sits directly upstream of a pipelined slave port, including a standard slave reached through a pipelined-to-standard adapter.
- Keeps up to MAX_OUT transfers outstanding and holds CYC until every strobed beat is acknowledged.
- Returns read data as an unthrottled stream.

Parameters:
- AW, 16, address width in bits; word address, increments by 1 per beat.
- DW, 16, data width in bits.
- LW, 8, burst length field width; a command carries len+1 beats, 1..2^LW.
- MAX_OUT, 4, maximum outstanding (strobed, not yet acked) beats; range 1..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_we  in  1  1 = write burst, 0 = read burst.
- cmd_adr  in  AW  start word address.
- cmd_len  in  LW  beats minus one.
- wr_valid  in  1  write data available.
- wr_ready  out  1  write data consumed this cycle.
- wr_dat  in  DW  write data.
- rd_valid  out  1  read data valid; one-cycle pulse, no backpressure.
- rd_dat  out  DW  read data.
- busy  out  1  cycle in progress (equals cyc).
- cyc_o, stb_o, we_o  out  1  Wishbone cycle, strobe and write enable.
- adr_o  out  AW  Wishbone address.
- dat_o  out  DW  Wishbone write data.
- ack_i, stall_i  in  1  Wishbone acknowledge and stall.
- dat_i  in  DW  Wishbone read data.

Behaviour:
- Reset (rst=0, async): state IDLE. cyc_o, stb_o, we_o, cmd_ready, wr_ready, rd_valid and busy = 0. adr_o, dat_o and rd_dat = 0. Counters cleared.
- Reset mid-burst drops CYC immediately. The slave must treat the dropped CYC as an abort.
- State IDLE:
  - cmd_ready=1.
  - On accept: latch we, adr, beats_left=len+1 and out_cnt=0, then go to ISSUE.
  - cyc_o rises in the cycle after accept.
- State ISSUE:
  - cyc_o=1.
  - stb_o=1 when beats_left>0, out_cnt<MAX_OUT, and (we=0 or wr_valid).
  - For writes, dat_o=wr_dat combinationally.
  - A beat is issued on stb_o & ~stall_i. On issue: adr += 1 (wraps modulo 2^AW), beats_left -= 1, and for writes wr_ready=1 in that same cycle.
  - While stall_i=1: stb_o, adr_o, we_o and dat_o are held stable and wr_ready=0.
  - When beats_left reaches 0, go to DRAIN.
- State DRAIN:
  - stb_o=0, cyc_o=1.
  - When out_cnt=0 (counting an ack in the current cycle), cyc_o drops the next cycle and the state returns to IDLE.
  - A zero-ack corner case is impossible: a command always has ≥1 beat.
- out_cnt rules:
  - +1 on issue, −1 on ack_i.
  - Issue and ack in the same cycle leave it unchanged.
  - ack_i while out_cnt=0 (and no issue that cycle) is a protocol error: ignored, counter saturates at 0.
- Read return:
  - rd_valid=ack_i & cyc_o & ~we, registered.
  - rd_dat=dat_i, registered.
  - Latency: 1 cycle after ack.
- Back-to-back commands: a new command is accepted only in IDLE. Minimum gap is one idle cycle between bursts (CYC low ≥1 cycle).
- Throughput: 1 beat/cycle when stall_i=0 and acks keep up; limited to MAX_OUT per ack round-trip.

Optional Feature:
- Macro: WB_MASTER_TIMEOUT_EN.
- With the macro defined:
  - Adds parameter TIMEOUT (default 255) and output err_timeout (1 bit, registered, reset 0).
  - A watchdog counts consecutive cycles with cyc_o=1 and no ack_i, and is cleared by any ack.
  - Reaching TIMEOUT drops cyc/stb the next cycle, pulses err_timeout for 1 cycle, discards remaining beats, and returns to IDLE.
- Without the macro: no port, no counter; the master waits forever.

Decomposition:
- Package wb_pkg holds:
  - state_t enum {IDLE, ISSUE, DRAIN};
  - default AW/DW/LW constants;
  - a cmd_t packed struct {we, adr, len}.
- One natural sub-module: wb_outstanding_cnt, an up/down counter with full (=MAX_OUT) and empty flags, and simultaneous inc/dec handling.
- Everything else stays in the top module.

Test Plan:
- Single read: cmd_adr=0x0010, len=0; slave acks the cycle after stb, dat_i=0xBEEF → one stb at adr 0x0010; rd_valid pulses once with 0xBEEF; cyc low 1 cycle after the ack.
- 8-beat write, slave stall=0, ack 1 cycle later, wr_valid held 1 → 8 consecutive stb cycles, adr 0x0100..0x0107, dat_o = wr_dat stream, 8 wr_ready pulses, cyc spans 9 cycles.
- Stall pattern: slave stall = stb & ~ack, 4-beat read from 0x00FF with AW=8 wrap → stb/adr held during stall; addresses FF,00,01,02; exactly 4 rd_valid pulses.
- MAX_OUT=2, slave delays ack by 5 cycles on a 6-beat read → out_cnt never exceeds 2; stb deasserts while full; all 6 beats complete in order.
- Write with wr_valid gaps, wr_valid toggling 1,0,1,0 on a 4-beat burst → stb only when wr_valid=1; no beat issued without data; wr_ready count = 4.
- Reset asserted mid-burst, after 3 of 8 beats issued → cyc/stb 0 immediately; after release: IDLE, cmd_ready=1, out_cnt=0; with WB_MASTER_TIMEOUT_EN, a slave that never acks gives err_timeout at cycle TIMEOUT.
